// File: rtl/video_sig_gen.sv
// Video timing generator: raster position counters plus registered sync,
// active-draw, new-frame and frame-count outputs, all aligned to one pixel.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT       = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] H_SYNC_BEG  = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [10:0] H_SYNC_END  = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT       = 10'(ACTIVE_LINES);
  localparam logic [9:0]  V_SYNC_BEG  = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [9:0]  V_SYNC_END  = 10'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [5:0]  FC_LAST     = 6'(FPS - 1);

  // ST_IDLE: reset just released, next edge presents (0,0); ST_RUN: advancing.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_reg, state_next;
  logic [10:0] h_reg, h_next;
  logic [9:0]  v_reg, v_next;
  logic        hs_reg, hs_next;
  logic        vs_reg, vs_next;
  logic        ad_reg, ad_next;
  logic        nf_reg, nf_next;
  logic [5:0]  fc_reg, fc_next;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next position and its decode; outputs are registered from these so every
  // output describes the position being presented in the same cycle.
  always_comb begin
    state_next = state_reg;
    h_next     = '0;
    v_next     = '0;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (h_reg == H_LAST) begin
          h_next = '0;
          v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
        end else begin
          h_next = h_reg + 11'd1;
          v_next = v_reg;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ad_next = (h_next < H_ACT) && (v_next < V_ACT);
    hs_next = (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
    vs_next = (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
    nf_next = (state_reg == ST_RUN) && (h_next == H_ACT) && (v_next == V_ACT);

    fc_next = fc_reg;
    if (nf_next) begin
      fc_next = (fc_reg == FC_LAST) ? 6'd0 : fc_reg + 6'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_reg  <= '0;
      v_reg  <= '0;
      hs_reg <= 1'b0;
      vs_reg <= 1'b0;
      ad_reg <= 1'b0;
      nf_reg <= 1'b0;
      fc_reg <= '0;
    end else begin
      h_reg  <= h_next;
      v_reg  <= v_next;
      hs_reg <= hs_next;
      vs_reg <= vs_next;
      ad_reg <= ad_next;
      nf_reg <= nf_next;
      fc_reg <= fc_next;
    end
  end

  assign hcount_out = h_reg;
  assign vcount_out = v_reg;
  assign hs_out     = hs_reg;
  assign vs_out     = vs_reg;
  assign ad_out     = ad_reg;
  assign nf_out     = nf_reg;
  assign fc_out     = fc_reg;

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: a full-size instance for line timing and a small
// instance for whole-frame, frame-count and mid-frame reset behaviour.
module tb_video_sig_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [10:0] ha, hb;
  logic [9:0]  va, vb;
  logic        hsa, vsa, ada, nfa, hsb, vsb, adb, nfb;
  logic [5:0]  fca, fcb;

  video_sig_gen dut_a (
    .clk_in(clk), .rst_in(rst_a),
    .hcount_out(ha), .vcount_out(va), .hs_out(hsa), .vs_out(vsa),
    .ad_out(ada), .nf_out(nfa), .fc_out(fca)
  );

  video_sig_gen #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
    .ACTIVE_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .FPS(3)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b),
    .hcount_out(hb), .vcount_out(vb), .hs_out(hsb), .vs_out(vsb),
    .ad_out(adb), .nf_out(nfb), .fc_out(fcb)
  );

  int errors = 0;
  int checks = 0;
  int cnt_a  = -1;
  int cnt_b  = -1;
  bit en     = 1'b0;

  // Cycles since reset release: the first edge afterwards is cycle 0.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) cnt_a <= -1;
    else       cnt_a <= cnt_a + 1;
  end
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) cnt_b <= -1;
    else       cnt_b <= cnt_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs t cycles after release, from raster arithmetic alone.
  function automatic logic [30:0] model(input int t, input int ah, input int hfp, input int hsw,
                                        input int hbp, input int al, input int vfp, input int vsw,
                                        input int vbp, input int fps);
    int ht, vt, frame, h, v, off, np;
    logic hs, vs, ad, nf;
    ht    = ah + hfp + hsw + hbp;
    vt    = al + vfp + vsw + vbp;
    frame = ht * vt;
    h     = t % ht;
    v     = (t / ht) % vt;
    hs    = (h >= ah + hfp) && (h < ah + hfp + hsw);
    vs    = (v >= al + vfp) && (v < al + vfp + vsw);
    ad    = (h < ah) && (v < al);
    nf    = (h == ah) && (v == al);
    off   = al * ht + ah;
    np    = (t >= off) ? (t - off) / frame + 1 : 0;
    return {11'(h), 10'(v), hs, vs, ad, nf, 6'(np % fps)};
  endfunction

  always @(negedge clk) begin
    if (en) begin
      check("seq_a", {1'b0, ha, va, hsa, vsa, ada, nfa, fca},
            (cnt_a >= 0) ? {1'b0, model(cnt_a, 1280, 110, 40, 220, 720, 5, 5, 20, 60)} : 32'd0);
      check("seq_b", {1'b0, hb, vb, hsb, vsb, adb, nfb, fcb},
            (cnt_b >= 0) ? {1'b0, model(cnt_b, 8, 2, 2, 2, 4, 1, 1, 1, 3)} : 32'd0);
    end
  end

  initial begin
    int hs_cnt, ad_cnt, nf_cnt;
    hs_cnt = 0; ad_cnt = 0; nf_cnt = 0;
    #1 en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_all_zero", {1'b0, ha, va, hsa, vsa, ada, nfa, fca}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      if (i < 1650) begin
        hs_cnt += int'(hsa);
        ad_cnt += int'(ada);
      end
      nf_cnt += int'(nfb);
      if (i == 0) begin
        check("a_first_h", ha, 0);   check("a_first_v", va, 0);
        check("a_first_ad", ada, 1); check("a_first_hs", hsa, 0);
        check("a_first_vs", vsa, 0); check("a_first_nf", nfa, 0);
        check("a_first_fc", fca, 0);
      end
      if (i == 1279) check("a_ad_1279", ada, 1);
      if (i == 1280) check("a_ad_1280", ada, 0);
      if (i == 1389) check("a_hs_1389", hsa, 0);
      if (i == 1390) check("a_hs_1390", hsa, 1);
      if (i == 1429) check("a_hs_1429", hsa, 1);
      if (i == 1430) check("a_hs_1430", hsa, 0);
      if (i == 1649) check("a_h_1649", ha, 1649);
      if (i == 1650) begin
        check("a_wrap_h", ha, 0); check("a_wrap_v", va, 1);
      end
      if (i == 9)  check("b_hs_9", hsb, 0);
      if (i == 10) check("b_hs_10", hsb, 1);
      if (i == 12) check("b_hs_12", hsb, 0);
      if (i == 69) check("b_vs_69", vsb, 0);
      if (i == 70) check("b_vs_70", vsb, 1);
      if (i == 83) check("b_vs_83", vsb, 1);
      if (i == 84) check("b_vs_84", vsb, 0);
      if (i == 63) begin
        check("b_nf_63", nfb, 0); check("b_fc_63", fcb, 0);
      end
      if (i == 64) begin
        check("b_nf_64", nfb, 1); check("b_fc_64", fcb, 1);
      end
      if (i == 97) begin
        check("b_last_h", hb, 13); check("b_last_v", vb, 6);
      end
      if (i == 98) begin
        check("b_frame_wrap_h", hb, 0); check("b_frame_wrap_v", vb, 0);
      end
      if (i == 259) check("b_fc_259", fcb, 2);
      if (i == 260) begin
        check("b_nf_260", nfb, 1); check("b_fc_wrap", fcb, 0);
      end
    end
    check("a_hs_cycles", hs_cnt, 40);
    check("a_ad_cycles", ad_cnt, 1280);
    check("b_nf_pulses", nf_cnt, 35);

    // Mid-frame asynchronous reset, applied between clock edges.
    @(posedge clk);
    #1;
    check("b_fc_before_rst", fcb, 2);
    check("a_ad_before_rst", ada, 1);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    check("async_rst_a", {1'b0, ha, va, hsa, vsa, ada, nfa, fca}, 32'd0);
    check("async_rst_b", {1'b0, hb, vb, hsb, vsb, adb, nfb, fcb}, 32'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("b_restart_h", hb, 0); check("b_restart_v", vb, 0);
        check("b_restart_ad", adb, 1); check("b_restart_fc", fcb, 0);
        check("a_restart_h", ha, 0); check("a_restart_ad", ada, 1);
      end
      if (i == 64) check("b_restart_fc_64", fcb, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_sig_gen.md
VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

Interface
REQ-001 SHALL have parameter ACTIVE_H_PIXELS, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 110: pixels from end of active line to hsync start.
REQ-003 SHALL have parameter H_SYNC_WIDTH, default 40: hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK_PORCH, default 220: pixels from hsync end to end of line.
REQ-005 SHALL have parameter ACTIVE_LINES, default 720: active lines per frame.
REQ-006 SHALL have parameter V_FRONT_PORCH, default 5: lines from end of active region to vsync start.
REQ-007 SHALL have parameter V_SYNC_WIDTH, default 5: vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK_PORCH, default 20: lines from vsync end to end of frame.
REQ-009 SHALL have parameter FPS, default 60: frame-counter modulus.
REQ-010 SHALL have port clk_in, input, 1: pixel clock, all state on rising edge.
REQ-011 SHALL have port rst_in, input, 1: reset, asynchronous, active-high.
REQ-012 SHALL have port hcount_out, output, 11: horizontal pixel position.
REQ-013 SHALL have port vcount_out, output, 10: vertical line position.
REQ-014 SHALL have port hs_out, output, 1: horizontal sync, active-high; feeds encoder control_in[0].
REQ-015 SHALL have port vs_out, output, 1: vertical sync, active-high; feeds encoder control_in[1].
REQ-016 SHALL have port ad_out, output, 1: active draw; feeds encoder video-enable.
REQ-017 SHALL have port nf_out, output, 1: new-frame single-cycle pulse.
REQ-018 SHALL have port fc_out, output, 6: frame count, modulo FPS.

Function
REQ-019 SHALL define H_TOTAL = sum of the four H parameters (1650) and V_TOTAL = sum of the four V parameters (750).
REQ-020 SHALL register all outputs, with every output describing the same pixel position (hcount_out, vcount_out) in the same cycle; no combinational path to outputs.
REQ-021 SHALL increment hcount_out by 1 each clock; at H_TOTAL-1 it wraps to 0 and vcount_out increments.
REQ-022 SHALL wrap vcount_out from V_TOTAL-1 to 0 when hcount_out also wraps; position (H_TOTAL-1, V_TOTAL-1) is followed by (0,0).
REQ-023 SHALL assert ad_out iff hcount_out < ACTIVE_H_PIXELS and vcount_out < ACTIVE_LINES.
REQ-024 SHALL assert hs_out iff ACTIVE_H_PIXELS+H_FRONT_PORCH <= hcount_out < ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH (1390..1429), on every line including vertical blanking.
REQ-025 SHALL assert vs_out iff ACTIVE_LINES+V_FRONT_PORCH <= vcount_out < ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH (725..729), for the full line width.
REQ-026 SHALL pulse nf_out for exactly one cycle at position (ACTIVE_H_PIXELS, ACTIVE_LINES) = (1280,720), the first blanking pixel after the last active pixel.
REQ-027 SHALL update fc_out in the same cycle nf_out is high, to (fc+1) mod FPS; FPS-1 wraps to 0.
REQ-028 SHALL hold fc_out constant in all other cycles.
REQ-029 SHALL use an internal position register updated from next-position logic, so outputs are decoded from the next position and are valid in the cycle the position is presented.

Reset
REQ-030 SHALL, while rst_in is high, asynchronously force hcount_out=0, vcount_out=0, hs_out=0, vs_out=0, ad_out=0, nf_out=0, fc_out=0.
REQ-031 SHALL present position (0,0) with full decode (ad_out=1, hs_out=0, vs_out=0) on the first rising edge after rst_in falls; each later edge advances per REQ-021.
REQ-032 SHALL abandon the current frame on reset assertion mid-frame, with no nf_out pulse and no fc_out update; after release the sequence restarts per REQ-031.

Verification
REQ-033 Release reset, run 1 cycle -> (0,0), ad_out=1, hs_out=0, vs_out=0, nf_out=0, fc_out=0.
REQ-034 Run one line -> ad_out high for hcount 0..1279; hs_out high for hcount 1390..1429 (40 cycles); hcount 1649 followed by (0,1).
REQ-035 Run one frame -> exactly 921600 ad_out cycles; vs_out high for lines 725..729 (5x1650 cycles); nf_out high once at (1280,720); fc_out 0->1; (1649,749) followed by (0,0).
REQ-036 Run 60 frames -> fc_out reaches 59, then wraps to 0 on the 60th nf_out pulse; nf_out pulse spacing is exactly 1237500 cycles.
REQ-037 Assert rst_in asynchronously mid-frame at (500,300), between clock edges -> all outputs 0 immediately, before the next edge; after release, restart from (0,0) with fc_out=0.
REQ-038 Small parameter set (8,2,2,2 / 4,1,1,1 / FPS 3) -> H_TOTAL 14, V_TOTAL 7; hs_out at hcount 10..11; vs_out on line 5; fc_out wraps 2->0.
